// File: rtl/alu_pkg.sv
// Shared definitions for the RV32IM execute-stage ALU.
// The operation codes match the encoding that the decode stage emits.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SLL    = 5'b00001,
        OP_SLT    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_OR     = 5'b00110,
        OP_AND    = 5'b00111,
        OP_MUL    = 5'b01000,
        OP_MULH   = 5'b01001,
        OP_MULHSU = 5'b01010,
        OP_MULHU  = 5'b01011,
        OP_DIV    = 5'b01100,
        OP_DIVU   = 5'b01101,
        OP_REM    = 5'b01110,
        OP_REMU   = 5'b01111,
        OP_SUB    = 5'b10000,
        OP_SRA    = 5'b10101,
        OP_FWD    = 5'b11111
    } alu_op_e;

endpackage

// File: rtl/alu_muldiv.sv
// Single-cycle M-extension unit: one shared 64-bit multiplier and a
// combinational divider, including the divide-by-zero and overflow results.
module alu_muldiv
    import alu_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    logic        a_sign_s;
    logic        b_sign_s;
    logic [63:0] prod_s;
    logic        div_zero_s;
    logic        div_ovf_s;
    logic [31:0] b_safe_s;
    logic [31:0] quot_sgn_s;
    logic [31:0] rem_sgn_s;
    logic [31:0] quot_uns_s;
    logic [31:0] rem_uns_s;

    // Operand conditioning, multiplier and divider datapath.
    always_comb begin
        a_sign_s = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && a_i[31];
        b_sign_s = (op_i == OP_MULH) && b_i[31];
        // Sign-extending to 64 bits lets one unsigned multiplier serve all signedness mixes.
        prod_s   = {{32{a_sign_s}}, a_i} * {{32{b_sign_s}}, b_i};

        div_zero_s = (b_i == 32'h0000_0000);
        div_ovf_s  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
        // Dividing by 1 in the overflow case yields exactly the required quotient and zero remainder.
        b_safe_s   = (div_zero_s || div_ovf_s) ? 32'h0000_0001 : b_i;

        quot_sgn_s = $signed(a_i) / $signed(b_safe_s);
        rem_sgn_s  = $signed(a_i) % $signed(b_safe_s);
        quot_uns_s = a_i / b_safe_s;
        rem_uns_s  = a_i % b_safe_s;
    end

    // Result selection for the eight M-extension operations.
    always_comb begin
        result_o = 32'h0000_0000;
        case (op_i)
            OP_MUL:    result_o = prod_s[31:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  result_o = prod_s[63:32];
            OP_DIV:    result_o = div_zero_s ? 32'hFFFF_FFFF : quot_sgn_s;
            OP_DIVU:   result_o = div_zero_s ? 32'hFFFF_FFFF : quot_uns_s;
            OP_REM:    result_o = div_zero_s ? a_i : rem_sgn_s;
            OP_REMU:   result_o = div_zero_s ? a_i : rem_uns_s;
            default:   result_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/alu.sv
// RV32IM execute-stage ALU: combinational result plus a registered copy
// for the EX/MEM boundary.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [4:0]  SELECT,
    output logic [31:0] RESULT,
    output logic [31:0] RESULT_Q
);

    logic [4:0]  shamt_s;
    logic [31:0] muldiv_res_s;
    logic [31:0] result_d;
    logic [31:0] result_q;

    assign shamt_s = DATA2[4:0];

    alu_muldiv u_muldiv (
        .op_i     (SELECT),
        .a_i      (DATA1),
        .b_i      (DATA2),
        .result_o (muldiv_res_s)
    );

    // Base-ISA operations and final result mux.
    always_comb begin
        result_d = 32'h0000_0000;
        case (SELECT)
            OP_ADD:    result_d = DATA1 + DATA2;
            OP_SUB:    result_d = DATA1 - DATA2;
            OP_SLL:    result_d = DATA1 << shamt_s;
            OP_SRL:    result_d = DATA1 >> shamt_s;
            OP_SRA:    result_d = $signed(DATA1) >>> shamt_s;
            OP_SLT:    result_d = {31'h0, ($signed(DATA1) < $signed(DATA2))};
            OP_SLTU:   result_d = {31'h0, (DATA1 < DATA2)};
            OP_XOR:    result_d = DATA1 ^ DATA2;
            OP_OR:     result_d = DATA1 | DATA2;
            OP_AND:    result_d = DATA1 & DATA2;
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:
                       result_d = muldiv_res_s;
            OP_FWD:    result_d = DATA2;
            default:   result_d = 32'h0000_0000;
        endcase
    end

    // EX/MEM result register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q <= 32'h0000_0000;
        end else begin
            result_q <= result_d;
        end
    end

    assign RESULT   = result_d;
    assign RESULT_Q = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the RV32IM ALU: combinational ops,
// M-extension corner cases and the registered output with reset.
module tb_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [4:0]  SELECT;
    logic [31:0] RESULT;
    logic [31:0] RESULT_Q;

    int pass_cnt;
    int total_cnt;

    alu dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .SELECT   (SELECT),
        .RESULT   (RESULT),
        .RESULT_Q (RESULT_Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        SELECT = op;
        DATA1  = a;
        DATA2  = b;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        apply(OP_ADD, 32'd10, 32'd20);
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (RESULT_Q !== 32'h0) $display("FAIL reset_q got %h expected %h", RESULT_Q, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (RESULT !== 32'd30) $display("FAIL reset_comb_live got %h expected %h", RESULT, 32'd30);
        else pass_cnt++;
    endtask

    task automatic test_arith_logic();
        vec_t v [10];
        v = '{
            '{OP_ADD,  32'd10,        32'd20,        32'd30},
            '{OP_SUB,  32'd30,        32'd15,        32'd15},
            '{OP_SUB,  32'd0,         32'd1,         32'hFFFF_FFFF},
            '{OP_ADD,  32'hFFFF_FFFF, 32'd2,         32'd1},
            '{OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB},
            '{OP_OR,   32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011},
            '{OP_AND,  32'hF0F0_FFFF, 32'h3C3C_00FF, 32'h3030_00FF},
            '{OP_FWD,  32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000},
            '{OP_SLT,  32'd5,         32'd10,        32'd1},
            '{OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1}
        };
        for (int i = 0; i < 10; i++) begin
            apply(v[i].op, v[i].a, v[i].b);
            total_cnt++;
            if (RESULT !== v[i].exp)
                $display("FAIL arith_logic[%0d] op=%b got %h expected %h", i, v[i].op, RESULT, v[i].exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_compare_shift();
        vec_t v [9];
        v = '{
            '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0},
            '{OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1},
            '{OP_SLT,  32'd10,        32'd5,         32'd0},
            '{OP_SLL,  32'd5,         32'd2,         32'd20},
            '{OP_SLL,  32'd5,         32'h0000_0022, 32'd20},
            '{OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000},
            '{OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000},
            '{OP_SRA,  32'h4000_0000, 32'hFFFF_FFE1, 32'h2000_0000},
            '{OP_SRL,  32'hFFFF_FFFF, 32'd31,        32'd1}
        };
        for (int i = 0; i < 9; i++) begin
            apply(v[i].op, v[i].a, v[i].b);
            total_cnt++;
            if (RESULT !== v[i].exp)
                $display("FAIL cmp_shift[%0d] op=%b got %h expected %h", i, v[i].op, RESULT, v[i].exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_mul();
        vec_t v [6];
        v = '{
            '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1},
            '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0},
            '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF},
            '{OP_MUL,    32'd7,         32'd6,         32'd42},
            '{OP_MULHSU, 32'd2,         32'hFFFF_FFFF, 32'd1}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i].op, v[i].a, v[i].b);
            total_cnt++;
            if (RESULT !== v[i].exp)
                $display("FAIL mul[%0d] op=%b got %h expected %h", i, v[i].op, RESULT, v[i].exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_div();
        vec_t v [12];
        v = '{
            '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
            '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
            '{OP_DIVU, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF},
            '{OP_REMU, 32'h1234_5678, 32'd0,         32'h1234_5678},
            '{OP_DIV,  32'h8765_4321, 32'd0,         32'hFFFF_FFFF},
            '{OP_REM,  32'h8765_4321, 32'd0,         32'h8765_4321},
            '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
            '{OP_DIVU, 32'd100,       32'd7,         32'd14},
            '{OP_REMU, 32'd100,       32'd7,         32'd2},
            '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
            '{OP_DIVU, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC}
        };
        for (int i = 0; i < 12; i++) begin
            apply(v[i].op, v[i].a, v[i].b);
            total_cnt++;
            if (RESULT !== v[i].exp)
                $display("FAIL div[%0d] op=%b got %h expected %h", i, v[i].op, RESULT, v[i].exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_undefined();
        apply(5'b11000, 32'hDEAD_BEEF, 32'h1234_5678);
        total_cnt++;
        if (RESULT !== 32'h0) $display("FAIL undef_11000 got %h expected %h", RESULT, 32'h0);
        else pass_cnt++;
        apply(5'b10001, 32'hDEAD_BEEF, 32'h1234_5678);
        total_cnt++;
        if (RESULT !== 32'h0) $display("FAIL undef_10001 got %h expected %h", RESULT, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_registered();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(OP_ADD, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        total_cnt++;
        if (RESULT_Q !== 32'd3) $display("FAIL regq_add got %h expected %h", RESULT_Q, 32'd3);
        else pass_cnt++;
        apply(OP_SUB, 32'd30, 32'd15);
        total_cnt++;
        if (RESULT_Q !== 32'd3) $display("FAIL regq_hold got %h expected %h", RESULT_Q, 32'd3);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (RESULT_Q !== 32'd15) $display("FAIL regq_sub got %h expected %h", RESULT_Q, 32'd15);
        else pass_cnt++;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (RESULT_Q !== 32'h0) $display("FAIL regq_midreset got %h expected %h", RESULT_Q, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (RESULT !== 32'd15) $display("FAIL comb_during_reset got %h expected %h", RESULT, 32'd15);
        else pass_cnt++;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (RESULT_Q !== 32'd15) $display("FAIL regq_resume got %h expected %h", RESULT_Q, 32'd15);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        vec_t v [4];
        v = '{
            '{OP_MUL,  32'd9,         32'd9,  32'd81},
            '{OP_DIV,  32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6},
            '{OP_FWD,  32'd0,         32'hCAFE_0000, 32'hCAFE_0000},
            '{OP_SLL,  32'd1,         32'd31, 32'h8000_0000}
        };
        for (int i = 0; i < 4; i++) begin
            apply(v[i].op, v[i].a, v[i].b);
            @(posedge clk);
            #1;
            total_cnt++;
            if (RESULT_Q !== v[i].exp)
                $display("FAIL b2b[%0d] got %h expected %h", i, RESULT_Q, v[i].exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        SELECT    = 5'b00000;
        DATA1     = 32'h0;
        DATA2     = 32'h0;
        test_reset();
        test_arith_logic();
        test_compare_shift();
        test_mul();
        test_div();
        test_undefined();
        test_registered();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
